// File: rtl/mandelbrot_lane_array.sv
// Multi-lane Mandelbrot engine: raster pixels issued round-robin to NUM_LANES iteration lanes, retired in raster order.
// Pixel latency = issue cycle + (iterations+1) ITER cycles; out_valid never looks at out_ready and output data holds while stalled.
module mandelbrot_lane_array #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 20,
    parameter int ITER_W    = 8,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cfg_enable,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    input  logic signed [DATA_W-1:0] cfg_re_start,
    input  logic signed [DATA_W-1:0] cfg_im_start,
    input  logic signed [DATA_W-1:0] cfg_re_step,
    input  logic signed [DATA_W-1:0] cfg_im_step,
    input  logic [1:0]               cfg_color_mode,
    output logic [7:0]               r,
    output logic [7:0]               g,
    output logic [7:0]               b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int XW    = $clog2(X_SIZE + 1);
    localparam int YW    = $clog2(Y_SIZE + 1);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);
    localparam logic [XW-1:0]    LAST_X    = XW'(X_SIZE - 1);
    localparam logic [YW-1:0]    LAST_Y    = YW'(Y_SIZE - 1);
    localparam logic signed [DATA_W:0] ESC_LIM = (DATA_W+1)'(longint'(4) <<< FRAC_BITS);

    typedef enum logic [1:0] {L_IDLE, L_ITER, L_DONE} lane_st_t;

    logic [PTR_W-1:0]         ip, rp;
    logic                     frame_act;
    logic [XW-1:0]            ix, ox;
    logic [YW-1:0]            iy, oy;
    logic signed [DATA_W-1:0] re_acc, im_acc, lat_re_start, lat_re_step, lat_im_step;
    logic [ITER_W-1:0]        lat_max;
    logic [1:0]               lat_mode;

    logic signed [DATA_W-1:0] cur_re, cur_im, cur_re_step, cur_im_step, cur_re_base;
    logic [ITER_W-1:0]        cur_max;
    logic [1:0]               cur_mode;
    logic                     issue_go, retire_go;
    logic [NUM_LANES-1:0]     lane_idle, lane_done, lane_issue, lane_retire;
    logic [ITER_W-1:0]        lane_cnt  [NUM_LANES];
    logic [ITER_W-1:0]        lane_max  [NUM_LANES];
    logic [1:0]               lane_mode [NUM_LANES];

    // Before the frame has started, pixel (0,0) takes its values straight from cfg_*.
    always_comb begin
        cur_re      = frame_act ? re_acc       : cfg_re_start;
        cur_im      = frame_act ? im_acc       : cfg_im_start;
        cur_re_step = frame_act ? lat_re_step  : cfg_re_step;
        cur_im_step = frame_act ? lat_im_step  : cfg_im_step;
        cur_re_base = frame_act ? lat_re_start : cfg_re_start;
        cur_max     = frame_act ? lat_max      : cfg_max_iter;
        cur_mode    = frame_act ? lat_mode     : cfg_color_mode;
        issue_go    = (frame_act || cfg_enable) && lane_idle[ip];
        out_valid   = lane_done[rp];
        retire_go   = out_valid && out_ready;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_issue[i]  = issue_go && (ip == PTR_W'(i));
            lane_retire[i] = retire_go && (rp == PTR_W'(i));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ip           <= '0;
            frame_act    <= 1'b0;
            ix           <= '0;
            iy           <= '0;
            re_acc       <= '0;
            im_acc       <= '0;
            lat_re_start <= '0;
            lat_re_step  <= '0;
            lat_im_step  <= '0;
            lat_max      <= '0;
            lat_mode     <= '0;
        end else if (issue_go) begin
            ip <= (ip == LAST_LANE) ? '0 : ip + 1'b1;
            if (!frame_act) begin
                frame_act    <= 1'b1;
                lat_re_start <= cfg_re_start;
                lat_re_step  <= cfg_re_step;
                lat_im_step  <= cfg_im_step;
                lat_max      <= cfg_max_iter;
                lat_mode     <= cfg_color_mode;
            end
            if (ix == LAST_X) begin
                ix     <= '0;
                re_acc <= cur_re_base;
                im_acc <= cur_im + cur_im_step;
                if (iy == LAST_Y) begin
                    iy        <= '0;
                    frame_act <= 1'b0;
                end else begin
                    iy <= iy + 1'b1;
                end
            end else begin
                ix     <= ix + 1'b1;
                re_acc <= cur_re + cur_re_step;
                im_acc <= cur_im;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rp <= '0;
            ox <= '0;
            oy <= '0;
        end else if (retire_go) begin
            rp <= (rp == LAST_LANE) ? '0 : rp + 1'b1;
            if (ox == LAST_X) begin
                ox <= '0;
                oy <= (oy == LAST_Y) ? '0 : oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_st_t                   st, st_nxt;
        logic signed [DATA_W-1:0]   zr, zi, cre, cim, zr2, zi2, zri;
        logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri;
        logic signed [DATA_W:0]     mag;
        logic [ITER_W-1:0]          cnt, mx;
        logic [1:0]                 md;
        logic                       stop, is_idle, is_done, unused_prod;

        // Slicing the full product at FRAC_BITS is the arithmetic shift followed by truncation.
        always_comb begin
            p_rr = $signed({{DATA_W{zr[DATA_W-1]}}, zr}) * $signed({{DATA_W{zr[DATA_W-1]}}, zr});
            p_ii = $signed({{DATA_W{zi[DATA_W-1]}}, zi}) * $signed({{DATA_W{zi[DATA_W-1]}}, zi});
            p_ri = $signed({{DATA_W{zr[DATA_W-1]}}, zr}) * $signed({{DATA_W{zi[DATA_W-1]}}, zi});
            zr2  = p_rr[FRAC_BITS +: DATA_W];
            zi2  = p_ii[FRAC_BITS +: DATA_W];
            zri  = p_ri[FRAC_BITS-1 +: DATA_W];
            mag  = {zr2[DATA_W-1], zr2} + {zi2[DATA_W-1], zi2};
            stop = (mag > ESC_LIM) || (cnt == mx);
        end
        assign unused_prod = ^{p_rr, p_ii, p_ri};

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) st <= L_IDLE;
            else        st <= st_nxt;
        end

        always_comb begin
            st_nxt = st;
            unique case (st)
                L_IDLE:  if (lane_issue[i])  st_nxt = L_ITER;
                L_ITER:  if (stop)           st_nxt = L_DONE;
                L_DONE:  if (lane_retire[i]) st_nxt = L_IDLE;
                default: st_nxt = L_IDLE;
            endcase
        end

        always_comb begin
            is_idle = (st == L_IDLE);
            is_done = (st == L_DONE);
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                zr  <= '0;
                zi  <= '0;
                cre <= '0;
                cim <= '0;
                cnt <= '0;
                mx  <= '0;
                md  <= '0;
            end else if (lane_issue[i]) begin
                zr  <= '0;
                zi  <= '0;
                cnt <= '0;
                cre <= cur_re;
                cim <= cur_im;
                mx  <= cur_max;
                md  <= cur_mode;
            end else if (st == L_ITER && !stop) begin
                zr  <= zr2 - zi2 + cre;
                zi  <= zri + cim;
                cnt <= cnt + 1'b1;
            end
        end

        assign lane_idle[i] = is_idle;
        assign lane_done[i] = is_done;
        assign lane_cnt[i]  = cnt;
        assign lane_max[i]  = mx;
        assign lane_mode[i] = md;
    end

    logic [ITER_W-1:0] sel_cnt, sel_max;
    logic [1:0]        sel_mode;
    logic [ITER_W+7:0] cnt_ext;
    logic [7:0]        c1, c2;
    logic              unused_cnt_hi;

    always_comb begin
        sel_cnt  = lane_cnt[rp];
        sel_max  = lane_max[rp];
        sel_mode = lane_mode[rp];
        cnt_ext  = {8'd0, sel_cnt};
        c1       = cnt_ext[7:0];
        c2       = {c1[6:0], 1'b0};
        r        = 8'd0;
        g        = 8'd0;
        b        = 8'd0;
        if (out_valid && sel_cnt != sel_max) begin
            if (sel_mode == 2'd1) begin
                r = c1 + c2;
                g = c2;
                b = c1;
            end else begin
                r = c1;
                g = c1;
                b = c1;
            end
        end
        out_sof    = out_valid && (ox == '0) && (oy == '0);
        out_eol    = out_valid && (ox == LAST_X);
        frame_done = retire_go && (ox == LAST_X) && (oy == LAST_Y);
        busy       = frame_act || !(&lane_idle);
    end
    assign unused_cnt_hi = ^cnt_ext;

endmodule

// File: tb/tb_mandelbrot_lane_array.sv
// Directed bench for mandelbrot_lane_array on an 8x4 frame with 4 lanes; every pixel checked against hand-worked colours.
module tb_mandelbrot_lane_array;
    localparam int NL = 4, DW = 32, FB = 20, IW = 8, XS = 8, YS = 4;
    localparam int NPIX = XS * YS;
    localparam logic signed [DW-1:0] ONE = 32'sd1 <<< FB;

    logic                 aclk, areset, cfg_enable, out_ready;
    logic [IW-1:0]        cfg_max_iter;
    logic signed [DW-1:0] cfg_re_start, cfg_im_start, cfg_re_step, cfg_im_step;
    logic [1:0]           cfg_color_mode;
    logic [7:0]           r, g, b;
    logic                 out_valid, out_sof, out_eol, busy, frame_done;

    mandelbrot_lane_array #(
        .NUM_LANES(NL), .DATA_W(DW), .FRAC_BITS(FB), .ITER_W(IW), .X_SIZE(XS), .Y_SIZE(YS)
    ) u_dut (
        .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_max_iter(cfg_max_iter),
        .cfg_re_start(cfg_re_start), .cfg_im_start(cfg_im_start), .cfg_re_step(cfg_re_step),
        .cfg_im_step(cfg_im_step), .cfg_color_mode(cfg_color_mode), .r(r), .g(g), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .busy(busy), .frame_done(frame_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_chk = 0, n_pass = 0;
    int acc = 0, fd_cnt = 0;
    bit hold_rdy = 0, rand_rdy = 0, exp_tab = 0;
    logic [23:0] exp_rgb = 24'h0;
    logic [23:0] tab_row0 [XS];
    logic [23:0] tab_row1 [XS];
    logic        prev_stall = 1'b0;
    logic [26:0] prev_word = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [23:0] tab_lookup(input int px, input int py);
        if (py == 0) return tab_row0[px];
        if (py == 1) return tab_row1[px];
        return 24'h030201;
    endfunction

    always @(posedge aclk) begin
        #1;
        out_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Scoreboard: raster position comes from the bench's own acceptance count.
    always @(negedge aclk) begin
        if (areset) begin
            acc        = 0;
            prev_stall = 1'b0;
        end else begin
            int pix, px, py;
            if (prev_stall)
                check("stall_hold", 64'({r, g, b, out_sof, out_eol, out_valid}), 64'(prev_word));
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) begin
                pix = acc % NPIX;
                px  = pix % XS;
                py  = pix / XS;
                check("pix_rgb", 64'({r, g, b}), 64'(exp_tab ? tab_lookup(px, py) : exp_rgb));
                check("pix_sof", 64'(out_sof), 64'(pix == 0));
                check("pix_eol", 64'(out_eol), 64'(px == XS - 1));
                check("pix_last", 64'(frame_done), 64'(pix == NPIX - 1));
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {r, g, b, out_sof, out_eol, out_valid};
        end
    end

    task automatic set_cfg(input logic [IW-1:0] m, input logic [1:0] mode,
                           input logic signed [DW-1:0] rs, input logic signed [DW-1:0] ims,
                           input logic signed [DW-1:0] rst, input logic signed [DW-1:0] imt);
        cfg_max_iter   = m;
        cfg_color_mode = mode;
        cfg_re_start   = rs;
        cfg_im_start   = ims;
        cfg_re_step    = rst;
        cfg_im_step    = imt;
    endtask

    task automatic start_frame();
        @(negedge aclk) cfg_enable = 1'b1;
        @(negedge aclk) cfg_enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge aclk);
            k++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int k = 0;
        while (acc < target && k < budget) begin
            @(negedge aclk);
            k++;
        end
        check(tag, 64'(acc >= target), 64'(1));
    endtask

    initial begin
        int n, base, fd_base;
        tab_row0 = '{24'h000000, 24'h000000, 24'h000000, 24'h090603,
                     24'h060402, 24'h030201, 24'h030201, 24'h030201};
        tab_row1 = '{24'h030201, 24'h030201, 24'h060402, 24'h030201,
                     24'h030201, 24'h030201, 24'h030201, 24'h030201};
        areset     = 1'b1;
        cfg_enable = 1'b0;
        out_ready  = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rgb", 64'({r, g, b}), 64'(0));
        check("rst_flags", 64'({out_sof, out_eol, frame_done}), 64'(0));

        // c=(0,0), M=100: 1 issue edge + 101 ITER cycles, black everywhere
        set_cfg(100, 0, 0, 0, 0, 0);
        exp_rgb = 24'h000000;
        base = acc; fd_base = fd_cnt;
        @(negedge aclk) cfg_enable = 1'b1;
        n = 0;
        while (n < 300) begin
            @(posedge aclk); n++;
            @(negedge aclk);
            if (n == 1) cfg_enable = 1'b0;
            if (out_valid) break;
        end
        check("lat_m100", 64'(n), 64'(102));
        check("lat_sof", 64'(out_sof), 64'(1));
        wait_idle("t1_idle", 3000);
        check("t1_pixels", 64'(acc - base), 64'(NPIX));
        check("t1_frames", 64'(fd_cnt - fd_base), 64'(1));

        // c=(2.0,0) ramp: cnt=2 -> 06/04/02, random stalls
        rand_rdy = 1;
        set_cfg(100, 1, 2 * ONE, 0, 0, 0);
        exp_rgb = 24'h060402;
        base = acc; fd_base = fd_cnt;
        start_frame();
        wait_idle("t2_idle", 2000);
        check("t2_pixels", 64'(acc - base), 64'(NPIX));
        check("t2_frames", 64'(fd_cnt - fd_base), 64'(1));

        // c=(0.25,0), M=255 grey: never escapes -> black rather than ff
        set_cfg(255, 0, ONE / 4, 0, 0, 0);
        exp_rgb = 24'h000000;
        base = acc; fd_base = fd_cnt;
        start_frame();
        wait_idle("t3_idle", 6000);
        check("t3_pixels", 64'(acc - base), 64'(NPIX));
        check("t3_frames", 64'(fd_cnt - fd_base), 64'(1));

        // Raster frame re=-2+x, im=2y; re_start changed mid-frame, enable dropped at pixel 5
        exp_tab = 1;
        set_cfg(20, 1, -2 * ONE, 0, ONE, 2 * ONE);
        base = acc; fd_base = fd_cnt;
        @(negedge aclk) cfg_enable = 1'b1;
        wait_acc("t4_acc3", base + 3, 500);
        cfg_re_start = 5 * ONE;
        wait_acc("t4_acc5", base + 5, 500);
        cfg_enable = 1'b0;
        wait_idle("t4_idle", 2000);
        check("t4_pixels", 64'(acc - base), 64'(NPIX));
        check("t4_frames", 64'(fd_cnt - fd_base), 64'(1));
        repeat (40) @(negedge aclk);
        check("t4_no_restart", 64'(acc - base), 64'(NPIX));
        check("t4_busy_low", 64'(busy), 64'(0));

        // Next frame picks up the new re_start: c=(5,0) -> cnt 1
        exp_tab = 0;
        set_cfg(20, 1, 5 * ONE, 0, 0, 0);
        exp_rgb = 24'h030201;
        base = acc;
        start_frame();
        wait_idle("t5_idle", 2000);
        check("t5_pixels", 64'(acc - base), 64'(NPIX));

        // M=0: all black, full-rate frame with ready held high
        rand_rdy = 0;
        set_cfg(0, 1, 3 * ONE, ONE, ONE, ONE);
        exp_rgb = 24'h000000;
        base = acc; fd_base = fd_cnt;
        @(negedge aclk) cfg_enable = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge aclk); n++;
            @(negedge aclk);
            if (n == 1) cfg_enable = 1'b0;
            if (frame_done) break;
        end
        check("m0_cycles", 64'(n), 64'(33));
        wait_idle("t6_idle", 200);
        check("t6_pixels", 64'(acc - base), 64'(NPIX));

        // Async reset while lanes hold finished pixels
        hold_rdy = 1;
        set_cfg(100, 1, 2 * ONE, 0, 0, 0);
        exp_rgb = 24'h060402;
        start_frame();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("pre_rst_rgb", 64'({r, g, b}), 64'(24'h060402));
        #2 areset = 1'b1;
        #1;
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_rgb", 64'({r, g, b}), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        @(negedge aclk);
        @(negedge aclk) areset = 1'b0;
        hold_rdy = 0;
        fd_base = fd_cnt;
        start_frame();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("post_rst_sof", 64'(out_sof), 64'(1));
        wait_idle("t7_idle", 500);
        check("t7_pixels", 64'(acc), 64'(NPIX));
        check("t7_frames", 64'(fd_cnt - fd_base), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
